// File: rtl/i2c_slave_frame_ctrl_pkg.sv
// Shared types and constants for the NITTA I2C slave frame sequencer.
package i2c_slave_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  localparam logic       I2C_ACK           = 1'b0;
  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_slave_frame_ctrl_bus_cond_detect.sv
// Bus condition decoder: registers SCL/SDA and emits START, STOP and SCL edge pulses.
module i2c_bus_cond_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic r_scl_q;
  logic r_sda_q;

  // Reset to the idle bus level so leaving reset does not fake an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= i_scl;
      r_sda_q <= i_sda;
    end
  end

  assign o_start    = i_scl & r_scl_q & r_sda_q & ~i_sda;
  assign o_stop     = i_scl & r_scl_q & ~r_sda_q & i_sda;
  assign o_scl_rise = i_scl & ~r_scl_q;
  assign o_scl_fall = ~i_scl & r_scl_q;

endmodule

// File: rtl/i2c_slave_frame_ctrl.sv
// I2C slave frame sequencer: START/STOP decode, address/ACK/data FSM, ping-pong swap.
// Optional feature macro: I2C_GENERAL_CALL_EN (also ACK general-call writes).
module i2c_slave_frame_ctrl
  import i2c_slave_frame_ctrl_pkg::*;
#(
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_DATA_WIDTH-2:0] ADDRES_DEVICE  = 7'h47,
  parameter int                        WORD_BYTES     = 4,
  parameter int                        SIZE_WORDS     = 2,
  parameter int                        CNT_WIDTH      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_scl,
  input  logic                      i_sda_in,
  output logic                      o_sda_oe,
  input  logic                      i_signal_cycle,
  output logic [I2C_DATA_WIDTH-1:0] o_rx_byte,
  output logic                      o_rx_valid,
  input  logic [I2C_DATA_WIDTH-1:0] i_tx_byte,
  output logic                      o_tx_req,
  output logic                      o_buf_sel,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_frame_invalid
);

  localparam int                   BW          = $clog2(I2C_DATA_WIDTH);
  localparam logic [BW-1:0]        LAST_BIT    = BW'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] FRAME_BYTES = CNT_WIDTH'(SIZE_WORDS * WORD_BYTES);

  logic w_start, w_stop, w_rise, w_fall;

  i2c_bus_cond_detect u_cond (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda_in),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall)
  );

  state_t                    r_state, w_state_nx;
  logic [BW-1:0]             r_bit_cnt, w_bit_cnt_nx;
  logic [I2C_DATA_WIDTH-2:0] r_shreg, w_shreg_nx;
  logic [I2C_DATA_WIDTH-2:0] r_tx_sh, w_tx_sh_nx;
  logic [CNT_WIDTH-1:0]      r_byte_cnt, w_byte_cnt_nx;
  logic [I2C_DATA_WIDTH-1:0] r_rx_byte, w_rx_byte_nx;
  logic                      r_rw, w_rw_nx;
  logic                      r_phase, w_phase_nx;
  logic                      r_busy, w_busy_nx;
  logic                      r_sda_oe, w_sda_oe_nx;
  logic                      r_rx_valid, w_rx_valid_nx;
  logic                      r_tx_req, w_tx_req_nx;
  logic                      r_frame_done, w_frame_done_nx;
  logic                      r_frame_inv, w_frame_inv_nx;
  logic                      r_buf_sel, w_buf_sel_nx;
  logic                      r_swap_pend, w_swap_pend_nx;
  logic [I2C_DATA_WIDTH-1:0] w_byte_in;
  logic                      w_last_bit;

  assign w_byte_in  = {r_shreg, i_sda_in};
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  function automatic logic addr_hit(input logic [I2C_DATA_WIDTH-1:0] b);
    logic hit;
    hit = (b[I2C_DATA_WIDTH-1:1] == ADDRES_DEVICE);
`ifdef I2C_GENERAL_CALL_EN
    if ((b[I2C_DATA_WIDTH-1:1] == (I2C_DATA_WIDTH-1)'(GENERAL_CALL_ADDR)) && !b[0])
      hit = 1'b1;
`endif
    return hit;
  endfunction

  // r_phase marks the second half of an ACK slot (ACK driven / master ACK seen)
  // and, in TX, that all data bits have been clocked out.
  always_comb begin
    w_state_nx      = r_state;
    w_bit_cnt_nx    = r_bit_cnt;
    w_shreg_nx      = r_shreg;
    w_tx_sh_nx      = r_tx_sh;
    w_byte_cnt_nx   = r_byte_cnt;
    w_rx_byte_nx    = r_rx_byte;
    w_rw_nx         = r_rw;
    w_phase_nx      = r_phase;
    w_busy_nx       = r_busy;
    w_sda_oe_nx     = r_sda_oe;
    w_rx_valid_nx   = 1'b0;
    w_tx_req_nx     = 1'b0;
    w_frame_done_nx = 1'b0;
    w_frame_inv_nx  = r_frame_inv;
    w_buf_sel_nx    = r_buf_sel;
    w_swap_pend_nx  = r_swap_pend;

    if (w_stop) begin
      w_state_nx   = ST_IDLE;
      w_sda_oe_nx  = 1'b0;
      w_phase_nx   = 1'b0;
      w_bit_cnt_nx = '0;
      w_busy_nx    = 1'b0;
      if (r_busy) begin
        w_frame_done_nx = 1'b1;
        w_frame_inv_nx  = !r_rw && (r_byte_cnt != FRAME_BYTES);
      end
    end else if (w_start) begin
      w_state_nx   = ST_ADDR;
      w_bit_cnt_nx = '0;
      w_shreg_nx   = '0;
      w_sda_oe_nx  = 1'b0;
      w_phase_nx   = 1'b0;
      if (r_state == ST_IDLE) w_byte_cnt_nx = '0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_rise) begin
          w_shreg_nx   = w_byte_in[I2C_DATA_WIDTH-2:0];
          w_bit_cnt_nx = r_bit_cnt + 1'b1;
          if (w_last_bit) begin
            w_bit_cnt_nx = '0;
            if (addr_hit(w_byte_in)) begin
              w_state_nx = ST_ADDR_ACK;
              w_rw_nx    = w_byte_in[0];
              w_busy_nx  = 1'b1;
            end else begin
              w_state_nx = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: if (w_fall) begin
          if (!r_phase) begin
            w_sda_oe_nx = 1'b1;
            w_phase_nx  = 1'b1;
            w_tx_req_nx = r_rw;
          end else begin
            w_phase_nx   = 1'b0;
            w_bit_cnt_nx = '0;
            if (r_rw) begin
              w_state_nx  = ST_TX;
              w_tx_sh_nx  = i_tx_byte[I2C_DATA_WIDTH-2:0];
              w_sda_oe_nx = !i_tx_byte[I2C_DATA_WIDTH-1];
            end else begin
              w_state_nx  = ST_RX;
              w_sda_oe_nx = 1'b0;
            end
          end
        end
        ST_RX: if (w_rise) begin
          w_shreg_nx   = w_byte_in[I2C_DATA_WIDTH-2:0];
          w_bit_cnt_nx = r_bit_cnt + 1'b1;
          if (w_last_bit) begin
            w_bit_cnt_nx  = '0;
            w_rx_byte_nx  = w_byte_in;
            w_rx_valid_nx = 1'b1;
            w_state_nx    = ST_RX_ACK;
            if (r_byte_cnt != {CNT_WIDTH{1'b1}}) w_byte_cnt_nx = r_byte_cnt + 1'b1;
          end
        end
        ST_RX_ACK: if (w_fall) begin
          if (!r_phase) begin
            w_sda_oe_nx = 1'b1;
            w_phase_nx  = 1'b1;
          end else begin
            w_sda_oe_nx = 1'b0;
            w_phase_nx  = 1'b0;
            w_state_nx  = ST_RX;
          end
        end
        ST_TX: begin
          if (w_rise) begin
            w_bit_cnt_nx = r_bit_cnt + 1'b1;
            if (w_last_bit) begin
              w_bit_cnt_nx = '0;
              w_phase_nx   = 1'b1;
            end
          end else if (w_fall) begin
            if (r_phase) begin
              w_sda_oe_nx = 1'b0;
              w_phase_nx  = 1'b0;
              w_state_nx  = ST_TX_ACK;
            end else begin
              w_sda_oe_nx = !r_tx_sh[I2C_DATA_WIDTH-2];
              w_tx_sh_nx  = {r_tx_sh[I2C_DATA_WIDTH-3:0], 1'b0};
            end
          end
        end
        ST_TX_ACK: begin
          if (w_rise) begin
            if (i_sda_in == I2C_ACK) begin
              w_tx_req_nx = 1'b1;
              w_phase_nx  = 1'b1;
            end else begin
              w_state_nx = ST_IGNORE;
            end
          end else if (w_fall && r_phase) begin
            w_phase_nx   = 1'b0;
            w_bit_cnt_nx = '0;
            w_state_nx   = ST_TX;
            w_tx_sh_nx   = i_tx_byte[I2C_DATA_WIDTH-2:0];
            w_sda_oe_nx  = !i_tx_byte[I2C_DATA_WIDTH-1];
          end
        end
        ST_IGNORE: w_sda_oe_nx = 1'b0;
        default: ;
      endcase
    end

    // Swap only while the registered state is IDLE, so a cycle request that
    // lands on the STOP clock is applied one clock after IDLE entry.
    if ((r_state == ST_IDLE) && (i_signal_cycle || r_swap_pend)) begin
      w_buf_sel_nx   = !r_buf_sel;
      w_swap_pend_nx = 1'b0;
    end else if (r_busy && i_signal_cycle) begin
      w_swap_pend_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_tx_sh      <= '0;
      r_byte_cnt   <= '0;
      r_rx_byte    <= '0;
      r_rw         <= 1'b0;
      r_phase      <= 1'b0;
      r_busy       <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_inv  <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_swap_pend  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_bit_cnt    <= w_bit_cnt_nx;
      r_shreg      <= w_shreg_nx;
      r_tx_sh      <= w_tx_sh_nx;
      r_byte_cnt   <= w_byte_cnt_nx;
      r_rx_byte    <= w_rx_byte_nx;
      r_rw         <= w_rw_nx;
      r_phase      <= w_phase_nx;
      r_busy       <= w_busy_nx;
      r_sda_oe     <= w_sda_oe_nx;
      r_rx_valid   <= w_rx_valid_nx;
      r_tx_req     <= w_tx_req_nx;
      r_frame_done <= w_frame_done_nx;
      r_frame_inv  <= w_frame_inv_nx;
      r_buf_sel    <= w_buf_sel_nx;
      r_swap_pend  <= w_swap_pend_nx;
    end
  end

  assign o_sda_oe        = r_sda_oe;
  assign o_rx_byte       = r_rx_byte;
  assign o_rx_valid      = r_rx_valid;
  assign o_tx_req        = r_tx_req;
  assign o_buf_sel       = r_buf_sel;
  assign o_busy          = r_busy;
  assign o_frame_done    = r_frame_done;
  assign o_frame_invalid = r_frame_inv;

endmodule

// File: tb/tb_i2c_slave_frame_ctrl.sv
// Directed bench for i2c_slave_frame_ctrl: bit-banged master on a wired-AND SDA line.
module tb_i2c_slave_frame_ctrl;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sig_cycle = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       sda_line;
  logic       sda_oe, rx_valid, tx_req, buf_sel, busy, frame_done, frame_invalid;
  logic [7:0] rx_byte;

  int vecs = 0;
  int fails = 0;

  int         rx_cnt = 0, txreq_cnt = 0, fd_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_list[0:3] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
  logic [1:0] tx_idx = 2'd0;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_frame_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_scl           (m_scl),
    .i_sda_in        (sda_line),
    .o_sda_oe        (sda_oe),
    .i_signal_cycle  (sig_cycle),
    .o_rx_byte       (rx_byte),
    .o_rx_valid      (rx_valid),
    .i_tx_byte       (tx_byte),
    .o_tx_req        (tx_req),
    .o_buf_sel       (buf_sel),
    .o_busy          (busy),
    .o_frame_done    (frame_done),
    .o_frame_invalid (frame_invalid)
  );

  // Event counters and a splitter stand-in that answers tx_req with the next byte.
  always @(posedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_byte);
    end
    if (tx_req) begin
      txreq_cnt <= txreq_cnt + 1;
      tx_byte   <= tx_list[tx_idx];
      tx_idx    <= tx_idx + 2'd1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (sda_oe)     oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  // Returns one clock after STOP is seen, while frame_done is high.
  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(1);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output int ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    read_bit(b);
    ack = (b == 1'b0) ? 1 : 0;
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic do_write(input logic [7:0] addr_b, input int n, input logic [7:0] first,
                          output int acks);
    int a;
    acks = 0;
    i2c_start();
    send_byte(addr_b, a); acks += a;
    for (int i = 0; i < n; i++) begin
      send_byte(first + 8'(i), a); acks += a;
    end
  endtask

  initial begin
    int         acks, a, b_rx, b_fd, b_oe, b_tx, b_log;
    logic       bit_v, old_sel;
    logic [7:0] r1, r2, r3;

    // Reset state
    wait_clk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_buf_sel", buf_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_invalid", frame_invalid, 0);
    rst = 1'b1;
    wait_clk(2);

    // 1: good 8-byte write
    b_rx = rx_cnt; b_fd = fd_cnt; b_log = rx_log.size();
    do_write(8'h8E, 8, 8'h01, acks);
    chk("t1_busy", busy, 1);
    chk("t1_acks", acks, 9);
    i2c_stop();
    chk("t1_fd_pulse", frame_done, 1);
    wait_clk(4);
    chk("t1_rx_count", rx_cnt - b_rx, 8);
    for (int i = 0; i < 8; i++)
      chk("t1_rx_byte", (rx_log.size() > b_log + i) ? rx_log[b_log + i] : 8'hxx, i + 1);
    chk("t1_fd_count", fd_cnt - b_fd, 1);
    chk("t1_invalid", frame_invalid, 0);
    chk("t1_busy_after", busy, 0);

    // 2: short write flags invalid; next good frame clears it
    b_fd = fd_cnt;
    do_write(8'h8E, 5, 8'h11, acks);
    i2c_stop(); wait_clk(4);
    chk("t2_acks", acks, 6);
    chk("t2_fd_count", fd_cnt - b_fd, 1);
    chk("t2_invalid", frame_invalid, 1);
    do_write(8'h8E, 8, 8'h21, acks);
    chk("t2_invalid_held", frame_invalid, 1);
    i2c_stop(); wait_clk(4);
    chk("t2_invalid_clr", frame_invalid, 0);

    // 3: foreign address
    b_rx = rx_cnt; b_fd = fd_cnt; b_oe = oe_cnt;
    do_write(8'hA0, 1, 8'h55, acks);
    chk("t3_busy", busy, 0);
    i2c_stop(); wait_clk(4);
    chk("t3_acks", acks, 0);
    chk("t3_oe_cycles", oe_cnt - b_oe, 0);
    chk("t3_rx_count", rx_cnt - b_rx, 0);
    chk("t3_fd_count", fd_cnt - b_fd, 0);

    // 4: read A5, ACK, 3C, NACK, then ignored
    b_fd = fd_cnt; b_tx = txreq_cnt;
    i2c_start();
    send_byte(8'h8F, a);
    chk("t4_addr_ack", a, 1);
    read_byte(r1); send_bit(1'b0);
    read_byte(r2); send_bit(1'b1);
    read_byte(r3);
    chk("t4_busy", busy, 1);
    i2c_stop(); wait_clk(4);
    chk("t4_byte0", r1, 8'hA5);
    chk("t4_byte1", r2, 8'h3C);
    chk("t4_ignored", r3, 8'hFF);
    chk("t4_tx_req", txreq_cnt - b_tx, 2);
    chk("t4_fd_count", fd_cnt - b_fd, 1);
    chk("t4_invalid", frame_invalid, 0);

    // 5: cycle request mid-frame is deferred to one clock after IDLE entry
    old_sel = buf_sel;
    i2c_start();
    send_byte(8'h8E, a); send_byte(8'h01, a); send_byte(8'h02, a);
    for (int i = 7; i >= 4; i--) send_bit(1'b0);
    sig_cycle = 1'b1; wait_clk(1); sig_cycle = 1'b0;
    wait_clk(2);
    chk("t5_hold_mid", buf_sel, old_sel);
    for (int i = 3; i >= 0; i--) send_bit(1'b1);
    read_bit(bit_v);
    for (int i = 4; i <= 8; i++) send_byte(8'(i), a);
    chk("t5_hold_end", buf_sel, old_sel);
    i2c_stop();
    chk("t5_hold_stop", buf_sel, old_sel);
    chk("t5_fd_pulse", frame_done, 1);
    wait_clk(1);
    chk("t5_swapped", buf_sel, !old_sel);
    wait_clk(3);
    // Request while idle swaps on the next clock, exactly once.
    sig_cycle = 1'b1; wait_clk(1); sig_cycle = 1'b0;
    chk("t5_idle_swap", buf_sel, old_sel);
    wait_clk(3);
    chk("t5_idle_once", buf_sel, old_sel);

    // 6: reset during the address ACK
    b_fd = fd_cnt;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h8E >> i);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2);
    chk("t6_ack_driven", sda_oe, 1);
    rst = 1'b0; wait_clk(1);
    chk("t6_oe_released", sda_oe, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b1; wait_clk(2);
    m_scl = 1'b0; wait_clk(Q);
    i2c_stop(); wait_clk(4);
    chk("t6_no_fd", fd_cnt - b_fd, 0);

    // General call write
    i2c_start();
    send_byte(8'h00, a);
`ifdef I2C_GENERAL_CALL_EN
    chk("t6_gc_ack", a, 1);
`else
    chk("t6_gc_ack", a, 0);
`endif
    i2c_stop(); wait_clk(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
